// File: rtl/ika9958_cpu_regwr_if.sv
// rtl/ika9958_cpu_regwr_if.sv - Z80-side CPU port bus into the VDP write front end
interface ika9958_cpu_regwr_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] mode;
    logic [7:0] db;

    modport master (
        output cs_n,
        output rd_n,
        output wr_n,
        output mode,
        output db
    );

    modport slave (
        input cs_n,
        input rd_n,
        input wr_n,
        input mode,
        input db
    );
endinterface

// File: rtl/ika9958_cpu_regwr.sv
// rtl/ika9958_cpu_regwr.sv - VDP CPU port decoder: register, palette, VRAM address and VRAM data writes
module ika9958_cpu_regwr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST_n,
    ika9958_cpu_regwr_if.slave   cpu,
    output logic                 o_REG_WE,
    output logic [5:0]           o_REG_ADDR,
    output logic [7:0]           o_REG_DATA,
    output logic                 o_PAL_WE,
    output logic [3:0]           o_PAL_ADDR,
    output logic [8:0]           o_PAL_DATA,
    output logic                 o_VADDR_WE,
    output logic [13:0]          o_VADDR_DATA,
    output logic                 o_VADDR_WR,
    output logic                 o_VRAM_WE,
    output logic                 o_VRAM_RE,
    output logic [7:0]           o_VRAM_DATA,
    output logic [7:0]           o_R16,
    output logic [7:0]           o_R17
);

    // Fewer than two stages would not be a metastability guard.
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic { P1_IDLE, P1_HAVE1 } p1_state_t;
    typedef enum logic { PAL_IDLE, PAL_HAVE1 } pal_state_t;

    logic [NS-1:0] cs_sync, rd_sync, wr_sync;
    logic          wr_lvl, rd_lvl, wr_prev, rd_prev;
    logic          wr_fall, rd_fall;

    logic          ev_wr, ev_rd;
    logic [1:0]    ev_mode;
    logic [7:0]    ev_db;

    p1_state_t     p1_state, p1_state_nx;
    pal_state_t    pal_state, pal_state_nx;
    logic [7:0]    p1_byte, p1_byte_nx;
    logic [7:0]    pal_byte, pal_byte_nx;
    logic [7:0]    r16, r16_nx, r17, r17_nx;

    logic          reg_we_nx, pal_we_nx, vaddr_we_nx, vaddr_wr_nx, vram_we_nx, vram_re_nx;
    logic [5:0]    reg_addr_nx;
    logic [7:0]    reg_data_nx, vram_data_nx;
    logic [3:0]    pal_addr_nx;
    logic [8:0]    pal_data_nx;
    logic [13:0]   vaddr_data_nx;

    logic          reg_wr_hit;
    logic [5:0]    reg_wr_num;
    logic [7:0]    reg_wr_val;

    // Bring the asynchronous strobes into the clock domain; idle level is high.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
        end else begin
            cs_sync <= {cs_sync[NS-2:0], cpu.cs_n};
            rd_sync <= {rd_sync[NS-2:0], cpu.rd_n};
            wr_sync <= {wr_sync[NS-2:0], cpu.wr_n};
        end
    end

    assign wr_lvl  = wr_sync[NS-1] | cs_sync[NS-1];
    assign rd_lvl  = rd_sync[NS-1] | cs_sync[NS-1];
    assign wr_fall = wr_prev & ~wr_lvl;
    // A write wins if both strobes fall together so only one event is raised.
    assign rd_fall = rd_prev & ~rd_lvl & ~wr_fall;

    // Edge detect and capture of port number / data on the detect cycle.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
            ev_wr   <= 1'b0;
            ev_rd   <= 1'b0;
            ev_mode <= '0;
            ev_db   <= '0;
        end else begin
            wr_prev <= wr_lvl;
            rd_prev <= rd_lvl;
            ev_wr   <= wr_fall;
            ev_rd   <= rd_fall;
            if (wr_fall || rd_fall) begin
                ev_mode <= cpu.mode;
                ev_db   <= cpu.db;
            end
        end
    end

    // Protocol decode: byte phases, pointer updates and next strobe values.
    always_comb begin
        p1_state_nx   = p1_state;
        pal_state_nx  = pal_state;
        p1_byte_nx    = p1_byte;
        pal_byte_nx   = pal_byte;
        r16_nx        = r16;
        r17_nx        = r17;
        reg_we_nx     = 1'b0;
        reg_addr_nx   = o_REG_ADDR;
        reg_data_nx   = o_REG_DATA;
        pal_we_nx     = 1'b0;
        pal_addr_nx   = o_PAL_ADDR;
        pal_data_nx   = o_PAL_DATA;
        vaddr_we_nx   = 1'b0;
        vaddr_data_nx = o_VADDR_DATA;
        vaddr_wr_nx   = o_VADDR_WR;
        vram_we_nx    = 1'b0;
        vram_re_nx    = 1'b0;
        vram_data_nx  = o_VRAM_DATA;
        reg_wr_hit    = 1'b0;
        reg_wr_num    = '0;
        reg_wr_val    = '0;

        if (ev_wr) begin
            case (ev_mode)
                2'd0: begin
                    vram_we_nx   = 1'b1;
                    vram_data_nx = ev_db;
                end
                2'd1: begin
                    if (p1_state == P1_IDLE) begin
                        p1_byte_nx  = ev_db;
                        p1_state_nx = P1_HAVE1;
                    end else begin
                        p1_state_nx = P1_IDLE;
                        if (ev_db[7]) begin
                            reg_wr_hit = 1'b1;
                            reg_wr_num = ev_db[5:0];
                            reg_wr_val = p1_byte;
                        end else begin
                            vaddr_we_nx   = 1'b1;
                            vaddr_data_nx = {ev_db[5:0], p1_byte};
                            vaddr_wr_nx   = ev_db[6];
                        end
                    end
                end
                2'd2: begin
                    if (pal_state == PAL_IDLE) begin
                        pal_byte_nx  = ev_db;
                        pal_state_nx = PAL_HAVE1;
                    end else begin
                        pal_state_nx = PAL_IDLE;
                        pal_we_nx    = 1'b1;
                        pal_addr_nx  = r16[3:0];
                        pal_data_nx  = {ev_db[2:0], pal_byte[6:4], pal_byte[2:0]};
                        r16_nx       = {r16[7:4], r16[3:0] + 4'd1};
                    end
                end
                default: begin
                    // Indirect access never writes R#17 itself.
                    if (r17[5:0] != 6'd17) begin
                        reg_wr_hit = 1'b1;
                        reg_wr_num = r17[5:0];
                        reg_wr_val = ev_db;
                    end
                    if (!r17[7]) begin
                        r17_nx = {r17[7:6], r17[5:0] + 6'd1};
                    end
                end
            endcase
        end else if (ev_rd) begin
            if (ev_mode == 2'd0) begin
                vram_re_nx = 1'b1;
            end else if (ev_mode == 2'd1) begin
                p1_state_nx = P1_IDLE;
            end
        end

        // Shared register-write path; the pointer registers are mirrored here.
        if (reg_wr_hit) begin
            reg_we_nx   = 1'b1;
            reg_addr_nx = reg_wr_num;
            reg_data_nx = reg_wr_val;
            if (reg_wr_num == 6'd16) begin
                r16_nx       = reg_wr_val;
                pal_state_nx = PAL_IDLE;
            end
            if (reg_wr_num == 6'd17) begin
                r17_nx = reg_wr_val;
            end
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            p1_state     <= P1_IDLE;
            pal_state    <= PAL_IDLE;
            p1_byte      <= '0;
            pal_byte     <= '0;
            r16          <= '0;
            r17          <= '0;
            o_REG_WE     <= 1'b0;
            o_REG_ADDR   <= '0;
            o_REG_DATA   <= '0;
            o_PAL_WE     <= 1'b0;
            o_PAL_ADDR   <= '0;
            o_PAL_DATA   <= '0;
            o_VADDR_WE   <= 1'b0;
            o_VADDR_DATA <= '0;
            o_VADDR_WR   <= 1'b0;
            o_VRAM_WE    <= 1'b0;
            o_VRAM_RE    <= 1'b0;
            o_VRAM_DATA  <= '0;
        end else begin
            p1_state     <= p1_state_nx;
            pal_state    <= pal_state_nx;
            p1_byte      <= p1_byte_nx;
            pal_byte     <= pal_byte_nx;
            r16          <= r16_nx;
            r17          <= r17_nx;
            o_REG_WE     <= reg_we_nx;
            o_REG_ADDR   <= reg_addr_nx;
            o_REG_DATA   <= reg_data_nx;
            o_PAL_WE     <= pal_we_nx;
            o_PAL_ADDR   <= pal_addr_nx;
            o_PAL_DATA   <= pal_data_nx;
            o_VADDR_WE   <= vaddr_we_nx;
            o_VADDR_DATA <= vaddr_data_nx;
            o_VADDR_WR   <= vaddr_wr_nx;
            o_VRAM_WE    <= vram_we_nx;
            o_VRAM_RE    <= vram_re_nx;
            o_VRAM_DATA  <= vram_data_nx;
        end
    end

    assign o_R16 = r16;
    assign o_R17 = r17;

endmodule

// File: tb/tb_ika9958_cpu_regwr.sv
// tb/tb_ika9958_cpu_regwr.sv - self-checking bench for ika9958_cpu_regwr
module tb_ika9958_cpu_regwr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_we, pal_we, vaddr_we, vaddr_wr, vram_we, vram_re;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data, vram_data, r16, r17;
    logic [3:0]  pal_addr;
    logic [8:0]  pal_data;
    logic [13:0] vaddr_data;

    ika9958_cpu_regwr_if bus ();

    ika9958_cpu_regwr #(.SYNC_STAGES(2)) dut (
        .i_EMUCLK     (clk),
        .i_RST_n      (rst_n),
        .cpu          (bus.slave),
        .o_REG_WE     (reg_we),
        .o_REG_ADDR   (reg_addr),
        .o_REG_DATA   (reg_data),
        .o_PAL_WE     (pal_we),
        .o_PAL_ADDR   (pal_addr),
        .o_PAL_DATA   (pal_data),
        .o_VADDR_WE   (vaddr_we),
        .o_VADDR_DATA (vaddr_data),
        .o_VADDR_WR   (vaddr_wr),
        .o_VRAM_WE    (vram_we),
        .o_VRAM_RE    (vram_re),
        .o_VRAM_DATA  (vram_data),
        .o_R16        (r16),
        .o_R17        (r17)
    );

    always #5 clk = ~clk;

    // kind: 1 reg, 2 palette, 3 vram address, 4 vram write, 5 vram read
    typedef struct packed {
        logic [2:0]  kind;
        logic [5:0]  addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        bit         rd;
        logic [1:0] mode;
        logic [7:0] db;
        logic [2:0] kind;
        logic [5:0] addr;
        logic [15:0] data;
        logic [7:0] r16;
        logic [7:0] r17;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tbl[$];

    int tests = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int repeat_cnt = 0;
    logic [4:0] prev_strb = '0;

    logic       m_p1, m_pal;
    logic [7:0] m_b1, m_pb, m_r16, m_r17;

    function automatic ev_t mk(input logic [2:0] k, input logic [5:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Record every strobe seen, and flag overlapping or stretched strobes.
    always @(negedge clk) begin
        logic [4:0] strb;
        strb = {vram_re, vram_we, vaddr_we, pal_we, reg_we};
        if (rst_n) begin
            if (reg_we)   obs_q.push_back(mk(3'd1, reg_addr, {8'h00, reg_data}));
            if (pal_we)   obs_q.push_back(mk(3'd2, {2'b00, pal_addr}, {7'h00, pal_data}));
            if (vaddr_we) obs_q.push_back(mk(3'd3, 6'd0, {1'b0, vaddr_wr, vaddr_data}));
            if (vram_we)  obs_q.push_back(mk(3'd4, 6'd0, {8'h00, vram_data}));
            if (vram_re)  obs_q.push_back(mk(3'd5, 6'd0, 16'h0000));
            if ($countones(strb) > 1) overlap_cnt++;
            if ((strb & prev_strb) != 5'd0) repeat_cnt++;
        end
        prev_strb = strb;
    end

    task automatic access(input bit rd, input logic [1:0] mode, input logic [7:0] db);
        @(posedge clk);
        #1;
        bus.mode = mode;
        bus.db   = db;
        bus.cs_n = 1'b0;
        if (rd) bus.rd_n = 1'b0;
        else    bus.wr_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic check_events(input string name);
        bit bad;
        bad = (obs_q.size() != exp_q.size());
        if (!bad) begin
            foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1;
        end
        tests++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got %0d events first=%h, required %0d events first=%h", name,
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0,
                     exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_ptrs(input string name, input logic [7:0] e16, input logic [7:0] e17);
        tests++;
        if (r16 !== e16 || r17 !== e17) begin
            errors++;
            $display("FAIL %s: R16/R17 got %h/%h required %h/%h", name, r16, r17, e16, e17);
        end
    endtask

    task automatic model_reg(input logic [5:0] n, input logic [7:0] v);
        exp_q.push_back(mk(3'd1, n, {8'h00, v}));
        if (n == 6'd16) begin
            m_r16 = v;
            m_pal = 1'b0;
        end
        if (n == 6'd17) m_r17 = v;
    endtask

    task automatic model_reset();
        m_p1 = 0; m_pal = 0; m_b1 = 0; m_pb = 0; m_r16 = 0; m_r17 = 0;
    endtask

    task automatic model_access(input bit rd, input logic [1:0] mode, input logic [7:0] db);
        logic [7:0] old17;
        int t;
        if (rd) begin
            if (mode == 2'd0) exp_q.push_back(mk(3'd5, 6'd0, 16'h0000));
            else if (mode == 2'd1) m_p1 = 1'b0;
        end else begin
            case (mode)
                2'd0: exp_q.push_back(mk(3'd4, 6'd0, {8'h00, db}));
                2'd1: begin
                    if (!m_p1) begin
                        m_p1 = 1'b1;
                        m_b1 = db;
                    end else begin
                        m_p1 = 1'b0;
                        if (db[7]) model_reg(db[5:0], m_b1);
                        else exp_q.push_back(mk(3'd3, 6'd0, 16'(int'(db[6]) * 16384 + int'(db[5:0]) * 256 + int'(m_b1))));
                    end
                end
                2'd2: begin
                    if (!m_pal) begin
                        m_pal = 1'b1;
                        m_pb  = db;
                    end else begin
                        m_pal = 1'b0;
                        exp_q.push_back(mk(3'd2, 6'(m_r16 % 16),
                            16'(int'(db[2:0]) * 64 + int'(m_pb[6:4]) * 8 + int'(m_pb[2:0]))));
                        m_r16 = 8'((m_r16 / 16) * 16 + ((m_r16 % 16) + 1) % 16);
                    end
                end
                default: begin
                    old17 = m_r17;
                    t = old17 % 64;
                    if (t != 17) model_reg(6'(t), db);
                    if (old17 < 8'h80) m_r17 = 8'((old17 / 64) * 64 + (t + 1) % 64);
                end
            endcase
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [70:0] all_out;
        int lat;
        bit found;
        bit rd;
        logic [1:0] md;
        logic [7:0] db;

        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.mode = 2'd0;
        bus.db   = 8'h00;

        tbl.push_back('{0, 2'd1, 8'h5A, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h87, 3'd1, 6'd7,  16'h005A, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h34, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{1, 2'd1, 8'h00, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h12, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h81, 3'd1, 6'd1,  16'h0012, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'hCD, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h4F, 3'd3, 6'd0,  16'h4FCD, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h22, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd0, 8'h33, 3'd4, 6'd0,  16'h0033, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h85, 3'd1, 6'd5,  16'h0022, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h3F, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd1, 8'h91, 3'd1, 6'd17, 16'h003F, 8'h00, 8'h3F});
        tbl.push_back('{0, 2'd3, 8'hAA, 3'd1, 6'd63, 16'h00AA, 8'h00, 8'h00});
        tbl.push_back('{0, 2'd3, 8'hBB, 3'd1, 6'd0,  16'h00BB, 8'h00, 8'h01});
        tbl.push_back('{0, 2'd1, 8'h91, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h01});
        tbl.push_back('{0, 2'd1, 8'h91, 3'd1, 6'd17, 16'h0091, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd3, 8'hCC, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd1, 8'h0F, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd1, 8'h90, 3'd1, 6'd16, 16'h000F, 8'h0F, 8'h91});
        tbl.push_back('{0, 2'd2, 8'h52, 3'd0, 6'd0,  16'h0000, 8'h0F, 8'h91});
        tbl.push_back('{0, 2'd2, 8'h06, 3'd2, 6'd15, 16'h01AA, 8'h00, 8'h91});
        tbl.push_back('{1, 2'd0, 8'h00, 3'd5, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{1, 2'd2, 8'h00, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{1, 2'd3, 8'h00, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd2, 8'h11, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd1, 8'h05, 3'd0, 6'd0,  16'h0000, 8'h00, 8'h91});
        tbl.push_back('{0, 2'd1, 8'h90, 3'd1, 6'd16, 16'h0005, 8'h05, 8'h91});
        tbl.push_back('{0, 2'd2, 8'h23, 3'd0, 6'd0,  16'h0000, 8'h05, 8'h91});
        tbl.push_back('{0, 2'd2, 8'h04, 3'd2, 6'd5,  16'h0113, 8'h06, 8'h91});

        repeat (3) @(posedge clk);
        @(negedge clk);
        all_out = {reg_we, reg_addr, reg_data, pal_we, pal_addr, pal_data, vaddr_we, vaddr_data,
                   vaddr_wr, vram_we, vram_re, vram_data, r16, r17};
        tests++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs got %h required 0", all_out);
        end
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        obs_q.delete();

        // Directed vector table.
        foreach (tbl[i]) begin
            access(tbl[i].rd, tbl[i].mode, tbl[i].db);
            if (tbl[i].kind != 3'd0) exp_q.push_back(mk(tbl[i].kind, tbl[i].addr, tbl[i].data));
            check_events($sformatf("vec%0d_events", i));
            check_ptrs($sformatf("vec%0d_ptrs", i), tbl[i].r16, tbl[i].r17);
        end

        // Reset between the two port-1 bytes discards the first byte.
        access(0, 2'd1, 8'h12);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        all_out = {reg_we, reg_addr, reg_data, pal_we, pal_addr, pal_data, vaddr_we, vaddr_data,
                   vaddr_wr, vram_we, vram_re, vram_data, r16, r17};
        tests++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        obs_q.delete();
        access(0, 2'd1, 8'h34);
        access(0, 2'd1, 8'h83);
        exp_q.push_back(mk(3'd1, 6'd3, 16'h0034));
        check_events("midreset_fresh_pair");

        // Strobe latency from the bus write edge.
        access(0, 2'd1, 8'h5A);
        @(posedge clk);
        #1;
        bus.mode = 2'd1;
        bus.db   = 8'h87;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        lat = -1;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            if (!found) begin
                @(posedge clk);
                @(negedge clk);
                if (reg_we) begin
                    found = 1;
                    lat = i;
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (6) @(posedge clk);
        tests++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency: got %0d clocks required 4", lat);
        end
        exp_q.push_back(mk(3'd1, 6'd7, 16'h005A));
        check_events("latency_single_strobe");

        // Randomized traffic against the reference model.
        apply_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            rd = ($urandom_range(0, 3) == 0);
            md = 2'($urandom_range(0, 3));
            db = 8'($urandom);
            model_access(rd, md, db);
            access(rd, md, db);
            check_events($sformatf("rand%0d_events", n));
            check_ptrs($sformatf("rand%0d_ptrs", n), m_r16, m_r17);
        end

        tests++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", overlap_cnt);
        end
        tests++;
        if (repeat_cnt != 0) begin
            errors++;
            $display("FAIL strobe_one_cycle: got %0d stretched strobes required 0", repeat_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
